// File: rtl/buf_req_ctrl.sv
// Request-side tag lookup controller for the lfu_finder replacement engine.
// It fills free buffers lowest index first, and uses the finder's victim index when every buffer is full.
//
// state  | meaning
// IDLE   | ready for a lookup; flush clears all valid bits
// LOOKUP | parallel tag compare; a miss with a free buffer installs here
// FILL   | all buffers full; request a victim, install at end of cycle
// RESP   | response strobe and reference report to the finder
module buf_req_ctrl #(
    parameter int BUF_BIT = 2,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_vld,
    input  logic [TAG_W-1:0]   acc_tag,
    output logic               acc_rdy,
    input  logic               flush,
    output logic               rsp_vld,
    output logic               rsp_hit,
    output logic [BUF_BIT-1:0] rsp_buf,
    output logic               new_buf_req,
    output logic [BUF_BIT-1:0] ref_buf_req,
    output logic               ref_buf_vld,
    input  logic [BUF_BIT-1:0] buf_num_replc
);

    localparam int NBUF = 1 << BUF_BIT;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t             state, state_nxt;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   tag_mem [NBUF];
    logic [NBUF-1:0]    vld;
    logic [BUF_BIT-1:0] idx_q;
    logic               hit_q;

    logic               hit, free, accept, mem_we;
    logic [BUF_BIT-1:0] hit_idx, free_idx, mem_idx;

    // Descending scan so that the lowest-numbered free entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (vld[i] && (tag_mem[i] == tag_q)) begin
                hit     = 1'b1;
                hit_idx = BUF_BIT'(i);
            end
            if (!vld[i]) begin
                free     = 1'b1;
                free_idx = BUF_BIT'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && acc_vld) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP:  state_nxt = (hit || free) ? RESP : FILL;
            FILL:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign acc_rdy     = (state == IDLE) && !flush;
    assign rsp_vld     = (state == RESP);
    assign rsp_hit     = rsp_vld && hit_q;
    assign rsp_buf     = idx_q;
    assign new_buf_req = (state == FILL);
    assign ref_buf_vld = rsp_vld;

    assign mem_we  = ((state == LOOKUP) && !hit && free) || (state == FILL);
    assign mem_idx = (state == FILL) ? buf_num_replc : free_idx;

    // Tag contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) tag_mem[mem_idx] <= tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            vld         <= '0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            ref_buf_req <= '0;
        end else begin
            if (accept) tag_q <= acc_tag;
            case (state)
                IDLE: begin
                    if (flush) vld <= '0;
                end
                LOOKUP: begin
                    if (hit) begin
                        idx_q       <= hit_idx;
                        hit_q       <= 1'b1;
                        ref_buf_req <= hit_idx;
                    end else if (free) begin
                        vld[free_idx] <= 1'b1;
                        idx_q         <= free_idx;
                        hit_q         <= 1'b0;
                        ref_buf_req   <= free_idx;
                    end
                end
                FILL: begin
                    idx_q       <= buf_num_replc;
                    hit_q       <= 1'b0;
                    ref_buf_req <= buf_num_replc;
                end
                default: ;
            endcase
        end
    end

endmodule
